// File: rtl/frontend_sequencer.sv
// frontend_sequencer: per-tile control FSM driving the compute frontend enables, addresses and arbiter phase
module frontend_sequencer #(
    parameter int addr_width_ia       = 11,
    parameter int wts_bram_addr_width = 4,
    parameter int ram_address_width   = 5,
    parameter int arb_steps           = 5,
    parameter int pipe_lat            = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [addr_width_ia-1:0]       num_ia_rows,
    input  logic [wts_bram_addr_width-1:0] wts_base,
    input  logic [ram_address_width-1:0]   addr_base,
    output logic [wts_bram_addr_width-1:0] wts_bram_addr,
    output logic                           enable_wts_rom,
    output logic                           wts_rf_enable,
    output logic                           addr_bram_enable,
    output logic [ram_address_width-1:0]   ram_address,
    output logic                           addr_rf_enable,
    output logic                           enable_IA_ram,
    output logic [addr_width_ia-1:0]       address_ia,
    output logic [2:0]                     control_arbiter,
    output logic [2:0]                     addr_arbiter_ctrl,
    output logic                           product_valid,
    output logic                           busy,
    output logic                           done
);
    typedef enum logic [2:0] {IDLE, WTS_FETCH, WTS_LOAD, COMPUTE, DRAIN, DONE} state_t;
    state_t state;
    logic [addr_width_ia-1:0] rows;
    logic [pipe_lat-1:0] vsr;
    logic [7:0] dcnt;
    logic arb_wrap, row_last;
    always_comb begin
        arb_wrap = control_arbiter == 3'(arb_steps - 1);
        row_last = address_ia == rows - addr_width_ia'(1);
    end
    assign product_valid = vsr[pipe_lat-1];
    // address_ia and control_arbiter double as the row and phase counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            rows              <= '0;
            vsr               <= '0;
            dcnt              <= '0;
            wts_bram_addr     <= '0;
            enable_wts_rom    <= 1'b0;
            wts_rf_enable     <= 1'b0;
            addr_bram_enable  <= 1'b0;
            ram_address       <= '0;
            addr_rf_enable    <= 1'b0;
            enable_IA_ram     <= 1'b0;
            address_ia        <= '0;
            control_arbiter   <= '0;
            addr_arbiter_ctrl <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            enable_wts_rom   <= 1'b0;
            addr_bram_enable <= 1'b0;
            wts_rf_enable    <= 1'b0;
            addr_rf_enable   <= 1'b0;
            done             <= 1'b0;
            vsr              <= pipe_lat'({vsr, state == COMPUTE});
            case (state)
                IDLE: if (start && num_ia_rows != '0) begin
                    state            <= WTS_FETCH;
                    rows             <= num_ia_rows;
                    wts_bram_addr    <= wts_base;
                    ram_address      <= addr_base;
                    enable_wts_rom   <= 1'b1;
                    addr_bram_enable <= 1'b1;
                    busy             <= 1'b1;
                end
                WTS_FETCH: begin
                    state          <= WTS_LOAD;
                    wts_rf_enable  <= 1'b1;
                    addr_rf_enable <= 1'b1;
                end
                WTS_LOAD: begin
                    state             <= COMPUTE;
                    enable_IA_ram     <= 1'b1;
                    address_ia        <= '0;
                    control_arbiter   <= '0;
                    addr_arbiter_ctrl <= '0;
                end
                COMPUTE: if (arb_wrap && row_last) begin
                    state         <= DRAIN;
                    enable_IA_ram <= 1'b0;
                    dcnt          <= '0;
                end else begin
                    control_arbiter   <= arb_wrap ? 3'd0 : control_arbiter + 3'd1;
                    addr_arbiter_ctrl <= arb_wrap ? 3'd0 : control_arbiter + 3'd1;
                    address_ia        <= address_ia + addr_width_ia'(arb_wrap);
                end
                DRAIN: if (dcnt == 8'(pipe_lat - 1)) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    dcnt <= dcnt + 8'd1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frontend_sequencer.sv
// tb_frontend_sequencer: scoreboard bench for two sequencer configurations
module tb_frontend_sequencer;
    typedef struct {int d; int c; int a; int b;} ev_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start [2];
    logic [10:0] num_ia_rows;
    logic [3:0] wts_base;
    logic [4:0] addr_base;
    logic [3:0] wts_bram_addr [2];
    logic enable_wts_rom [2], wts_rf_enable [2], addr_bram_enable [2];
    logic [4:0] ram_address [2];
    logic addr_rf_enable [2], enable_IA_ram [2];
    logic [10:0] address_ia [2];
    logic [2:0] control_arbiter [2], addr_arbiter_ctrl [2];
    logic product_valid [2], busy [2], done [2];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int bf [2];
    int bt [2];
    ev_t fetch_q[$], load_q[$], comp_q[$], val_q[$], done_q[$];
    ev_t e;

    genvar g;
    for (g = 0; g < 2; g++) begin : dut
        frontend_sequencer #(
            .addr_width_ia(11), .wts_bram_addr_width(4), .ram_address_width(5),
            .arb_steps(g == 0 ? 5 : 1), .pipe_lat(g == 0 ? 2 : 1)
        ) u (
            .clock(clock), .reset(reset), .start(start[g]),
            .num_ia_rows(num_ia_rows), .wts_base(wts_base), .addr_base(addr_base),
            .wts_bram_addr(wts_bram_addr[g]), .enable_wts_rom(enable_wts_rom[g]),
            .wts_rf_enable(wts_rf_enable[g]), .addr_bram_enable(addr_bram_enable[g]),
            .ram_address(ram_address[g]), .addr_rf_enable(addr_rf_enable[g]),
            .enable_IA_ram(enable_IA_ram[g]), .address_ia(address_ia[g]),
            .control_arbiter(control_arbiter[g]), .addr_arbiter_ctrl(addr_arbiter_ctrl[g]),
            .product_valid(product_valid[g]), .busy(busy[g]), .done(done[g])
        );
    end

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string n, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, x, cyc);
        end
    endtask

    function automatic int pending();
        return fetch_q.size() + load_q.size() + comp_q.size() + val_q.size() + done_q.size();
    endfunction

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                check("reset_zero", {wts_bram_addr[d], enable_wts_rom[d], wts_rf_enable[d],
                      addr_bram_enable[d], ram_address[d], addr_rf_enable[d], enable_IA_ram[d],
                      address_ia[d], control_arbiter[d], addr_arbiter_ctrl[d], product_valid[d],
                      busy[d], done[d]}, 64'd0);
            end else begin
                check("busy", busy[d], cyc >= bf[d] && cyc <= bt[d]);
                check("addr_bram_enable", addr_bram_enable[d], enable_wts_rom[d]);
                check("addr_rf_enable", addr_rf_enable[d], wts_rf_enable[d]);
                if (enable_wts_rom[d]) begin
                    check("fetch_expected", fetch_q.size() > 0, 1);
                    if (fetch_q.size() > 0) begin
                        e = fetch_q.pop_front();
                        check("fetch_dut", d, e.d);
                        check("fetch_cycle", cyc, e.c);
                        check("wts_bram_addr", wts_bram_addr[d], e.a);
                        check("ram_address", ram_address[d], e.b);
                    end
                end
                if (wts_rf_enable[d]) begin
                    check("load_expected", load_q.size() > 0, 1);
                    if (load_q.size() > 0) begin
                        e = load_q.pop_front();
                        check("load_dut", d, e.d);
                        check("load_cycle", cyc, e.c);
                    end
                end
                if (enable_IA_ram[d]) begin
                    check("compute_expected", comp_q.size() > 0, 1);
                    if (comp_q.size() > 0) begin
                        e = comp_q.pop_front();
                        check("compute_dut", d, e.d);
                        check("compute_cycle", cyc, e.c);
                        check("address_ia", address_ia[d], e.a);
                        check("control_arbiter", control_arbiter[d], e.b);
                        check("addr_arbiter_ctrl", addr_arbiter_ctrl[d], e.b);
                    end
                end
                if (product_valid[d]) begin
                    check("valid_expected", val_q.size() > 0, 1);
                    if (val_q.size() > 0) begin
                        e = val_q.pop_front();
                        check("valid_dut", d, e.d);
                        check("valid_cycle", cyc, e.c);
                    end
                end
                if (done[d]) begin
                    check("done_expected", done_q.size() > 0, 1);
                    if (done_q.size() > 0) begin
                        e = done_q.pop_front();
                        check("done_dut", d, e.d);
                        check("done_cycle", cyc, e.c);
                    end
                end
            end
        end
    end

    // start pulse in cycle t0: fetch t0+1, load t0+2, compute from t0+3 for n*s cycles,
    // valid delayed by p, done after p drain cycles
    task automatic start_tile(input int d, input int n, input int wb, input int ab);
        int s, p, t0;
        s = d == 0 ? 5 : 1;
        p = d == 0 ? 2 : 1;
        @(posedge clock); #1;
        t0 = cyc;
        num_ia_rows = 11'(n);
        wts_base = 4'(wb);
        addr_base = 5'(ab);
        start[d] = 1'b1;
        if (n != 0) begin
            fetch_q.push_back(ev_t'{d, t0 + 1, wb, ab});
            load_q.push_back(ev_t'{d, t0 + 2, 0, 0});
            for (int r = 0; r < n; r++)
                for (int a = 0; a < s; a++) comp_q.push_back(ev_t'{d, t0 + 3 + r * s + a, r, a});
            for (int k = 0; k < n * s; k++) val_q.push_back(ev_t'{d, t0 + 3 + p + k, 0, 0});
            done_q.push_back(ev_t'{d, t0 + 3 + n * s + p, 0, 0});
            bf[d] = t0 + 1;
            bt[d] = t0 + 3 + n * s + p;
        end
        @(posedge clock); #1;
        start[d] = 1'b0;
    endtask

    task automatic wait_done();
        int i = 0;
        while (pending() != 0 && i < 12000) begin
            @(negedge clock); #1;
            i++;
        end
        check("tile_complete", pending(), 0);
    endtask

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        num_ia_rows = '0;
        wts_base = '0;
        addr_base = '0;
        bf = '{1, 1};
        bt = '{0, 0};
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        num_ia_rows = 11'd2;
        start[0] = 1'b1;
        start[1] = 1'b1;
        @(posedge clock); #1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);

        start_tile(0, 2, 3, 7);
        repeat (5) @(posedge clock);
        #1;
        num_ia_rows = 11'd2;
        wts_base = 4'd9;
        start[0] = 1'b1;
        @(posedge clock); #1;
        start[0] = 1'b0;
        wait_done();

        start_tile(0, 0, 1, 1);
        start_tile(1, 0, 1, 1);
        repeat (4) @(posedge clock);

        start_tile(1, 1, 5, 9);
        wait_done();
        start_tile(1, 3, 2, 4);
        wait_done();

        start_tile(0, 2, 3, 7);
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b0;
        fetch_q.delete();
        load_q.delete();
        comp_q.delete();
        val_q.delete();
        done_q.delete();
        bf[0] = 1;
        bt[0] = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        start_tile(0, 2, 6, 12);
        wait_done();

        start_tile(0, 2047, 15, 31);
        wait_done();
        start_tile(0, 2047, 15, 31);
        wait_done();

        repeat (3) @(posedge clock);
        check("queues_drained", pending(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frontend_sequencer.md
Name: frontend_sequencer

Overview:
- Control FSM sitting directly upstream of the compute frontend; drives every enable, address and arbiter-select input that the frontend consumes (weights ROM, weights RF, address BRAM/RF, IA BRAM, arbiter controls).
- One tile is run per start pulse: fetch weights and address words, stream IA rows through all arbiter phases, drain the multiplier pipeline, then flag done.
- Also emits product_valid, aligned to the frontend's product/row/col/ch outputs, so the downstream accumulator knows when to capture.

Parameters:
addr_width_ia, 11, IA BRAM address width
wts_bram_addr_width, 4, weights ROM address width
ram_address_width, 5, address-module BRAM address width
arb_steps, 5, arbiter phases per IA row (legal range 1..8)
pipe_lat, 2, cycles from enable_IA_ram to a valid product (IA BRAM read + multiplier register)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle tile start request
num_ia_rows  input  addr_width_ia  IA rows in the tile; sampled on accepted start
wts_base  input  wts_bram_addr_width  weights ROM word for the tile; sampled on start
addr_base  input  ram_address_width  address BRAM word for the tile; sampled on start
wts_bram_addr  output  wts_bram_addr_width  weights ROM address
enable_wts_rom  output  1  weights ROM enable
wts_rf_enable  output  1  weights RF load enable
addr_bram_enable  output  1  address BRAM enable
ram_address  output  ram_address_width  address BRAM address
addr_rf_enable  output  1  address RF load enable
enable_IA_ram  output  1  IA BRAM enable
address_ia  output  addr_width_ia  IA BRAM address
control_arbiter  output  3  IA arbiter phase
addr_arbiter_ctrl  output  3  address arbiter phase (same value as control_arbiter)
product_valid  output  1  frontend product/addresses valid this cycle
busy  output  1  tile in progress
done  output  1  single-cycle tile-complete pulse

Behaviour:
- Reset: asynchronous on reset low; all outputs 0; FSM in IDLE; counters and shift register cleared. Reset mid-tile aborts with no done pulse.
- All outputs are registered.
- States: IDLE, WTS_FETCH, WTS_LOAD, COMPUTE, DRAIN, DONE.
- IDLE: all enables 0.
  - Start is accepted only in IDLE with num_ia_rows != 0. The block then latches num_ia_rows, wts_base and addr_base and goes to WTS_FETCH.
  - Start with num_ia_rows == 0 is ignored. Start in any other state is ignored.
- WTS_FETCH (1 cycle): enable_wts_rom=1, wts_bram_addr=wts_base, addr_bram_enable=1, ram_address=addr_base; next state WTS_LOAD.
- WTS_LOAD (1 cycle): wts_rf_enable=1, addr_rf_enable=1 (ROM/BRAM data valid after 1-cycle read latency); ROM/BRAM enables 0; row=0, arb=0; next state COMPUTE.
- COMPUTE: enable_IA_ram=1, address_ia=row, control_arbiter=addr_arbiter_ctrl=arb.
  - arb increments every cycle. When arb==arb_steps-1, arb wraps to 0 and row increments.
  - When row==num_ia_rows-1 and arb==arb_steps-1, the next state is DRAIN.
  - Duration is exactly num_ia_rows*arb_steps cycles.
- Valid tracking: a pipe_lat-deep shift register is fed with "state==COMPUTE"; product_valid is its output.
- DRAIN: all enables 0; lasts exactly pipe_lat cycles (counter); next state DONE.
- DONE (1 cycle): done=1; next state IDLE.
- busy=1 in every state except IDLE, including the DONE cycle.
- Address outputs hold their last value when their enable is 0.
- arb fits in 3 bits. row counter is addr_width_ia wide; num_ia_rows up to 2^addr_width_ia-1 is legal with no overflow.
- No back-to-back overlap: a new start is accepted at the earliest in the cycle after DONE.

Test Plan:
- Reset: hold reset low, toggle start -> all outputs 0, busy 0; release reset -> still IDLE.
- Basic tile: num_ia_rows=2, wts_base=3, addr_base=7, start at cycle 0 (defaults) ->
  - cycle 1: enable_wts_rom=1, wts_bram_addr=3, ram_address=7
  - cycle 2: wts_rf_enable=addr_rf_enable=1
  - cycles 3-12: enable_IA_ram=1, address_ia 0×5 then 1×5, control_arbiter 0,1,2,3,4,0,...,4
  - product_valid high cycles 5-14; done at cycle 15; busy high cycles 1-15.
- Zero rows / busy start: start with num_ia_rows=0 -> no state change. Start pulsed at cycle 6 of a running tile -> ignored; tile timing unchanged.
- Single row, arb_steps=1, pipe_lat=1: num_ia_rows=1 -> one COMPUTE cycle (cycle 3), product_valid cycle 4, DRAIN cycle 4, done cycle 5.
- Reset mid-COMPUTE: assert reset low at cycle 8 of the basic tile -> outputs 0 immediately, no done; a fresh start after release runs the full sequence from WTS_FETCH.
- Max rows and back-to-back tiles: num_ia_rows=2047 -> address_ia reaches 2046 with no wrap, 10235 COMPUTE cycles. Start in the cycle after done -> accepted; second tile identical.
